cache_arbiter: RTL
==================

# cache_arbiter

Round-robin arbiter and sequencer that shares one cache port among NREQ requesters (instruction fetch, data load/store, etc.). It owns the cache's operation/addr/data lines and issues one transaction at a time. For reads it waits out the cache's fixed CAS latency, then captures the data and returns it to the winning requester with a one-cycle done pulse. It sits between the requesting units and the cacheinterface master modport; the top level joins the split data lines onto the interface's bidirectional data bus.

## Interface
- NREQ, 2: number of requesters, ≥2
- WORD_W, 8: cache data width
- ADDR_W, 32: address width
- CAS_LATENCY, 1: cycles from op issue to read data valid, ≥1; elaboration-time assertion if 0

- clock  in  1  sole clock, rising edge
- resetN  in  1  asynchronous, active-low reset
- req  in  NREQ  request per requester; held with payload stable until its done
- req_write  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NREQ*WORD_W  packed write data
- gnt  out  NREQ  one-hot, high during the ISSUE cycle of the winner
- done  out  NREQ  one-hot, one-cycle completion pulse
- rdata  out  WORD_W  read data, valid while done is high for a read
- cache_op  out  2  0 = NOP, 1 = READ, 2 = WRITE (cachepkg::inst_t encoding)
- cache_addr  out  ADDR_W  transaction address
- cache_data_out  out  WORD_W  write data
- cache_data_oe  out  1  drive enable for the data bus
- cache_data_in  in  WORD_W  bus value sampled for reads

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: the eligible set is req & ~done.
  - If non-empty, pick the first eligible index at or after the pointer ptr, wrapping modulo NREQ.
  - Register op/addr/wdata for that index, set gnt, go to ISSUE.
  - Otherwise stay in IDLE with all outputs idle.
- ISSUE (exactly 1 cycle):
  - cache_op = READ or WRITE; cache_addr = the selected address.
  - Write: cache_data_out = wdata and cache_data_oe = 1, this cycle only.
  - ptr <= winner+1, wrapping NREQ-1 → 0.
  - Load cnt = CAS_LATENCY and go to WAIT.
- WAIT:
  - cache_op = NOP, cache_data_oe = 0, cnt decrements each cycle.
  - On the cycle where cnt == 1: for a read, capture cache_data_in into rdata; for both reads and writes, assert done[winner] for the next cycle and go to IDLE.
  - Writes also occupy WAIT, so the bus is never reused within the CAS window.
- Other requests arriving in ISSUE or WAIT are not granted; they wait for IDLE.
- Masking the done requester in IDLE prevents a held req from being reissued on its own done cycle.
- rdata holds its last value between reads. It is not updated for writes.
- cache_data_oe is never high on a read or in IDLE/WAIT.

## Timing
- Reset, asynchronous: state IDLE, ptr = 0, cnt = 0.
  - Every output resets to 0: gnt, done, rdata, cache_op (NOP), cache_addr, cache_data_out, cache_data_oe.
  - A transaction in flight is dropped and no done is produced.
- Let IDLE with an eligible request be cycle T-1.
  - ISSUE (gnt, op) is cycle T.
  - Read data must be valid on cache_data_in in cycle T+CAS_LATENCY; it is sampled at the end of that cycle.
  - done and rdata are valid in cycle T+CAS_LATENCY+1, with state IDLE.
- Another requester waiting during the done cycle issues at T+CAS_LATENCY+2.
- The same requester holding req issues at T+CAS_LATENCY+3.
- Simultaneous requests are resolved by ptr alone. Order from reset with all requesting: 0, 1, …, NREQ-1, 0.

## Test plan
- Single read, CAS=1: req[0] read addr 0x100 at T-1; bench drives cache_data_in = 0xA5 in T+1. Required: gnt[0]/READ/addr 0x100 in T; done[0] in T+2 with rdata 0xA5; oe always 0.
- Contention, CAS=1, req[0] and req[1] both held from reset. Required:
  - Grants alternate 0, 1, 0, 1, with ISSUE cycles 3 apart.
  - Each requester's done is followed by the other's ISSUE in the next cycle.
- Write, CAS=2: req[1] write addr 0x2000 data 0x3C. Required: in T, op=WRITE, cache_data_out 0x3C, oe=1; in T+1 and T+2, op=NOP and oe=0; done[1] in T+3; rdata unchanged.
- Latency blocking, CAS=3: req[0] read, and req[1] asserted in T+1. Required: no gnt[1] before T+5; done[0] in T+4 with data sampled from T+3.
- Reset mid-WAIT, CAS=3: assert resetN=0 in T+2. Required: all outputs 0 immediately and no done. After release, simultaneous req[1] and req[0] grant requester 0 first, since ptr = 0.
- Wrap-around, NREQ=4: only req[3], then req[3] and req[1] after its done. Required: ptr wraps to 0 after granting 3, and req[1] wins next.

Source files
------------

// File: rtl/cache_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_arbiter: round-robin sequencer sharing one cache port among NREQ
// requesters, one transaction at a time. Rev 1.0
// ---------------------------------------------------------------------------
module cache_arbiter #(
  parameter int NREQ        = 2,
  parameter int WORD_W      = 8,
  parameter int ADDR_W      = 32,
  parameter int CAS_LATENCY = 1
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*WORD_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [WORD_W-1:0]        rdata,
  output logic [1:0]               cache_op,
  output logic [ADDR_W-1:0]        cache_addr,
  output logic [WORD_W-1:0]        cache_data_out,
  output logic                     cache_data_oe,
  input  logic [WORD_W-1:0]        cache_data_in
);

  localparam int PTR_W = (NREQ < 2) ? 1 : $clog2(NREQ);
  localparam int CNT_W = (CAS_LATENCY < 1) ? 1 : $clog2(CAS_LATENCY + 1);

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  generate
    if (CAS_LATENCY < 1) begin : g_cas_check
      $error("cache_arbiter: CAS_LATENCY must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   winner;
  logic               win_write;

  logic [ADDR_W-1:0]  addr_arr  [NREQ];
  logic [WORD_W-1:0]  wdata_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*WORD_W +: WORD_W];
    end
  endgenerate

  // Masking done keeps a held request from reissuing in its own done cycle.
  logic [NREQ-1:0]  eligible;
  logic [PTR_W-1:0] pick;
  logic [PTR_W-1:0] cand;
  logic             pick_valid;

  always_comb begin
    eligible   = req & ~done;
    pick       = '0;
    cand       = '0;
    pick_valid = 1'b0;
    // Scan downward so the lowest offset from ptr is the last one kept.
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(ptr) + k) % NREQ);
      if (eligible[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state          <= S_IDLE;
      ptr            <= '0;
      cnt            <= '0;
      winner         <= '0;
      win_write      <= 1'b0;
      gnt            <= '0;
      done           <= '0;
      rdata          <= '0;
      cache_op       <= OP_NOP;
      cache_addr     <= '0;
      cache_data_out <= '0;
      cache_data_oe  <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            winner         <= pick;
            win_write      <= req_write[pick];
            gnt            <= NREQ'(1) << pick;
            cache_op       <= req_write[pick] ? OP_WRITE : OP_READ;
            cache_addr     <= addr_arr[pick];
            cache_data_out <= req_write[pick] ? wdata_arr[pick] : '0;
            cache_data_oe  <= req_write[pick];
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          gnt            <= '0;
          cache_op       <= OP_NOP;
          cache_addr     <= '0;
          cache_data_out <= '0;
          cache_data_oe  <= 1'b0;
          ptr            <= (winner == PTR_W'(NREQ - 1)) ? '0 : winner + 1'b1;
          cnt            <= CNT_W'(CAS_LATENCY);
          state          <= S_WAIT;
        end
        S_WAIT: begin
          // Writes also sit out the CAS window so the bus is never reused early.
          if (cnt == CNT_W'(1)) begin
            if (!win_write) rdata <= cache_data_in;
            done  <= NREQ'(1) << winner;
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
